// File: rtl/tile_assembler.sv
// tile_assembler: packs a row-major pixel stream into flattened TILE_DIM x TILE_DIM tiles (pixel 0 in MSBs).
// Define TILE_ASM_DOUBLE_BUF_EN to let the fill register run ahead of a held output tile.
module tile_assembler #(
  parameter int PIX_W    = 8,
  parameter int TILE_DIM = 4,
  parameter int TILE_W   = PIX_W*TILE_DIM*TILE_DIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic [TILE_W-1:0] tile_out,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic              sof_err,
  output logic [7:0]        drop_cnt
);
  localparam int N     = TILE_DIM*TILE_DIM;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);

  typedef enum logic {FILLING, FULL} fill_state_e;
  typedef enum logic {EMPTY, VALID} out_state_e;

  fill_state_e               fill_state_q, fill_state_d;
  out_state_e                out_state_q, out_state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N-1:0][PIX_W-1:0]   fill_q, fill_d;
  logic [N-1:0][PIX_W-1:0]   tile_q, tile_d;
  logic                      sof_err_q, sof_err_d;
  logic [7:0]                drop_cnt_q, drop_cnt_d;
  logic                      pix_acc, tile_acc, complete;
  logic [IDX_W-1:0]          slot;

`ifdef TILE_ASM_DOUBLE_BUF_EN
  assign pix_ready = !rst && (fill_state_q != FULL);
`else
  assign pix_ready = !rst && (out_state_q == EMPTY);
`endif

  assign tile_out   = tile_q;
  assign tile_valid = (out_state_q == VALID);
  assign sof_err    = sof_err_q;
  assign drop_cnt   = drop_cnt_q;

  always_comb begin
    fill_state_d = fill_state_q;
    out_state_d  = out_state_q;
    idx_d        = idx_q;
    fill_d       = fill_q;
    tile_d       = tile_q;
    sof_err_d    = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    pix_acc      = pix_valid && pix_ready;
    tile_acc     = (out_state_q == VALID) && tile_ready;
    // An SOF pixel restarts the tile at slot 0, abandoning whatever was partially filled.
    slot         = pix_sof ? '0 : idx_q;
    complete     = pix_acc && (slot == LAST);

    if (pix_acc) begin
      fill_d[LAST - slot] = pix_in;
      idx_d = complete ? '0 : slot + 1'b1;
      if (pix_sof && (idx_q != '0)) begin
        sof_err_d = 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    if (tile_acc) out_state_d = EMPTY;

    if (complete) begin
      if ((out_state_q == EMPTY) || tile_acc) begin
        tile_d      = fill_d;
        out_state_d = VALID;
      end else begin
        fill_state_d = FULL;
      end
    end else if ((fill_state_q == FULL) && tile_acc) begin
      tile_d       = fill_q;
      out_state_d  = VALID;
      fill_state_d = FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_state_q <= FILLING;
      out_state_q  <= EMPTY;
      idx_q        <= '0;
      fill_q       <= '0;
      tile_q       <= '0;
      sof_err_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      fill_state_q <= fill_state_d;
      out_state_q  <= out_state_d;
      idx_q        <= idx_d;
      fill_q       <= fill_d;
      tile_q       <= tile_d;
      sof_err_q    <= sof_err_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_tile_assembler.sv
// Bench for tile_assembler: directed scenarios plus random traffic against a pixel-queue/tile-queue model.
module tb_tile_assembler;
  localparam int N = 16;
`ifdef TILE_ASM_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, pix_valid, pix_sof, tile_ready;
  logic [7:0]   pix_in;
  logic         pix_ready, tile_valid, sof_err;
  logic [127:0] tile_out;
  logic [7:0]   drop_cnt;

  tile_assembler dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .tile_out(tile_out), .tile_valid(tile_valid),
    .tile_ready(tile_ready), .sof_err(sof_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pixels of the tile being gathered, completed tiles not yet consumed.
  byte unsigned cur[$];
  logic [127:0] tiles[$];
  int           drop_m = 0;
  bit           sof_m = 1'b0;
  bit           no_tile = 1'b1;
  int           sof_seen = 0;
  int           stalls = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit s, input bit tr);
    bit           exp_ready, exp_valid;
    logic [127:0] t;
    @(negedge clk);
    rst = r; pix_valid = v; pix_in = d; pix_sof = s; tile_ready = tr;
    #1;
    exp_ready = !r && (DB ? (tiles.size() < 2) : (tiles.size() == 0));
    exp_valid = (tiles.size() > 0);
    check("pix_ready", {127'd0, pix_ready}, {127'd0, exp_ready});
    check("tile_valid", {127'd0, tile_valid}, {127'd0, exp_valid});
    check("sof_err", {127'd0, sof_err}, {127'd0, sof_m});
    check("drop_cnt", {120'd0, drop_cnt}, 128'(drop_m));
    if (exp_valid) check("tile_out", tile_out, tiles[0]);
    else if (no_tile) check("tile_out_rst", tile_out, '0);
    if (sof_err) sof_seen++;
    if (!pix_ready) stalls++;

    if (r) begin
      cur.delete(); tiles.delete();
      drop_m = 0; sof_m = 1'b0; no_tile = 1'b1;
    end else begin
      sof_m = 1'b0;
      if (exp_valid && tr) void'(tiles.pop_front());
      if (v && exp_ready) begin
        if (s) begin
          if (cur.size() != 0) begin
            sof_m = 1'b1;
            if (drop_m < 255) drop_m++;
          end
          cur.delete();
        end
        cur.push_back(d);
        if (cur.size() == N) begin
          t = '0;
          foreach (cur[k]) t[127-8*k -: 8] = cur[k];
          tiles.push_back(t);
          cur.delete();
          no_tile = 1'b0;
        end
      end
    end
    @(posedge clk);
  endtask

  initial begin
    logic [127:0] fresh;
    rst = 1'b1; pix_valid = 1'b0; pix_in = '0; pix_sof = 1'b0; tile_ready = 1'b0;
    repeat (3) cycle(1, 0, 0, 0, 0);

    // Basic tile 4..64, consumed immediately.
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'(4*(i+1)), i == 0, 1);
    #2;
    check("t1_valid", {127'd0, tile_valid}, 128'd1);
    check("t1_data", tile_out, 128'h04080C10_14181C20_24282C30_34383C40);
    cycle(0, 0, 0, 0, 1);
    #2;
    check("t1_one_cycle", {127'd0, tile_valid}, 128'd0);

    // Backpressure: output held for a long stretch while pixels keep coming.
    repeat (2) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) cycle(0, 1, 8'(4*((i%16)+1)), (i%16) == 0, 0);
    repeat (20) cycle(0, 0, 0, 0, 1);

    // Mid-tile SOF realignment.
    repeat (2) cycle(1, 0, 0, 0, 0);
    sof_seen = 0;
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'(i+1), i == 0, 1);
    cycle(0, 1, 8'hAA, 1, 1);
    for (int i = 0; i < 15; i++) cycle(0, 1, 8'(8'h10+i), 0, 0);
    #2;
    check("sof_tile_valid", {127'd0, tile_valid}, 128'd1);
    check("sof_msb", {120'd0, tile_out[127:120]}, 128'hAA);
    check("sof_drop", {120'd0, drop_cnt}, 128'd1);
    check("sof_pulses", 128'(sof_seen), 128'd1);
    repeat (3) cycle(0, 0, 0, 0, 1);

    // 32 pixels back to back with the sink always ready.
    repeat (2) cycle(1, 0, 0, 0, 0);
    stalls = 0;
    for (int i = 0; i < 32; i++) cycle(0, 1, 8'($urandom), (i%16) == 0, 1);
    check("b2b_stalls", 128'(stalls), DB ? 128'd0 : 128'd1);
    repeat (20) cycle(0, 1, 8'($urandom), 0, 1);

    // Reset mid-fill, then a fresh tile.
    repeat (2) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 8'(8'h50+i), i == 0, 1);
    cycle(1, 0, 0, 0, 0);
    fresh = '0;
    for (int i = 0; i < 16; i++) begin
      fresh[127-8*i -: 8] = 8'(8'hC0+i);
      cycle(0, 1, 8'(8'hC0+i), 0, 0);
    end
    #2;
    check("rst_fresh_tile", tile_out, fresh);
    check("rst_drop", {120'd0, drop_cnt}, 128'd0);
    repeat (2) cycle(0, 0, 0, 0, 1);

    // Drop counter saturation: 257 SOF pixels give 256 discards.
    repeat (2) cycle(1, 0, 0, 0, 0);
    sof_seen = 0;
    for (int i = 0; i < 257; i++) cycle(0, 1, 8'(i), 1, 1);
    cycle(0, 0, 0, 0, 1);
    #2;
    check("sat_pulses", 128'(sof_seen), 128'd256);
    check("sat_drop", {120'd0, drop_cnt}, 128'd255);

    // Random traffic.
    repeat (2) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0));
    end
    repeat (5) cycle(0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
